fpmulit_radix: RTL

//  Parametrised fixed-point iterative multiplier, c = a*b, Q(N-D).D format.

---
 rtl/fpmulit_radix.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fpmulit_radix.sv
// fpmulit_radix: iterative fixed-point multiplier, c = a*b in Q(N-D).D format.
// Retires K multiplier bits per cycle, with optional half-up rounding and
// optional output saturation enabled by the macro FPMULIT_RADIX_SATURATE_EN.
//
// Handshake: a transfer happens on a rising clk edge where val and rdy are
// both high. snd_rdy is high only in IDLE and rcv_val only in DONE, so an
// operand accept and a result delivery never share a cycle. c is held stable
// while rcv_val=1 and rcv_rdy=0.
module fpmulit_radix #(
  parameter int N     = 32,
  parameter int D     = 16,
  parameter int K     = 1,
  parameter int SIGN  = 1,
  parameter int ROUND = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         snd_val,
  output logic         snd_rdy,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         rcv_val,
  input  logic         rcv_rdy,
  output logic [N-1:0] c,
  output logic [1:0]   dbg_state
);

  // Accumulator width: guard bits up to the full 2N product when saturating,
  // otherwise only the bits that can reach c (plus one sign bit).
`ifdef FPMULIT_RADIX_SATURATE_EN
  localparam int AW = 2*N + 1;
`else
  localparam int AW = N + D + 1;
`endif
  localparam int STEPS = N / K;
  localparam int CW    = $clog2(STEPS) + 1;
  localparam bit SGN   = (SIGN != 0);
  localparam logic [AW-1:0] RND =
    (ROUND != 0 && D > 0) ? (AW'(1) << ((D > 0) ? D - 1 : 0)) : '0;

  if (N % K != 0) begin : g_bad_k
    $error("fpmulit_radix: N must be a multiple of K");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] a_ext, a_sh, acc, acc_nxt;
  logic [N-1:0]  b_sh, c_nxt;
  logic [CW-1:0] count;
  logic          last_step;

  assign a_ext     = {{(AW-N){SGN & a[N-1]}}, a};
  assign last_step = (count == CW'(STEPS - 1));
  assign snd_rdy   = (state == IDLE);
  assign rcv_val   = (state == DONE);
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, iterate in BUSY, hold result in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (snd_val)   state_nxt = BUSY;
      BUSY:    if (last_step) state_nxt = DONE;
      DONE:    if (rcv_rdy)   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Add this cycle's K partial products; the signed MSB weight is negative.
  always_comb begin
    acc_nxt = acc;
    for (int j = 0; j < K; j++) begin
      if (b_sh[j]) begin
        if (SGN && last_step && (j == K - 1)) acc_nxt = acc_nxt - (a_sh << j);
        else                                  acc_nxt = acc_nxt + (a_sh << j);
      end
    end
  end

`ifdef FPMULIT_RADIX_SATURATE_EN
  logic [AW-1:0] rnd_sum, r_full;
  logic          ovf;

  // Round, shift to the output Q format and clamp to the N-bit range.
  always_comb begin
    rnd_sum = acc_nxt + RND;
    if (SGN) r_full = $signed(rnd_sum) >>> D;
    else     r_full = rnd_sum >> D;
    if (SGN) ovf = !((&r_full[AW-1:N-1]) || !(|r_full[AW-1:N-1]));
    else     ovf = |r_full[AW-1:N];
    if (!ovf)     c_nxt = r_full[N-1:0];
    else if (SGN) c_nxt = r_full[AW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    else          c_nxt = '1;
  end
`else
  // Round and shift; the low N bits are the same for arithmetic or logical
  // shift, so overflow simply wraps.
  always_comb begin
    c_nxt = N'((acc_nxt + RND) >> D);
  end
`endif

  // Datapath registers: latch operands on accept, step while BUSY, and
  // write c on the edge that completes the final step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      count <= '0;
      c     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (snd_val) begin
            a_sh  <= a_ext;
            b_sh  <= b;
            acc   <= '0;
            count <= '0;
          end
        end
        BUSY: begin
          acc   <= acc_nxt;
          a_sh  <= a_sh << K;
          b_sh  <= b_sh >> K;
          count <= count + CW'(1);
          if (last_step) c <= c_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
